// File: rtl/tree_pkg.sv
// Shared types for the node tree walker: node word layout, command and FSM encodings.
package tree_pkg;

  localparam int unsigned TREE_ID_W      = 8;
  localparam int unsigned TREE_ADDR_W    = 6;
  localparam int unsigned TREE_CNT_W     = 3;
  localparam int unsigned TREE_PAYLOAD_W = 16;

  // Packed LSB-first: field_id sits in the low bits, payload in the high bits.
  typedef struct packed {
    logic [TREE_PAYLOAD_W-1:0] payload;
    logic [TREE_CNT_W-1:0]     child_cnt;
    logic [TREE_ADDR_W-1:0]    first_child;
    logic [TREE_ID_W-1:0]      field_id;
  } node_word_t;

  typedef enum logic {
    LOOKUP = 1'b0,
    ASCEND = 1'b1
  } walker_op_e;

  typedef enum logic [2:0] {
    INIT,
    INIT_WAIT,
    IDLE,
    SCAN,
    CMP,
    ASC_RD,
    ASC_WAIT,
    RESP
  } walker_state_e;

  localparam node_word_t NODE_NULL = '0;

endpackage

// File: rtl/node_tree_stack.sv
// LIFO of ancestor node addresses; push and pop must never be asserted together.
module node_tree_stack #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign wr_ptr  = PTR_W'(cnt_q);
  assign rd_ptr  = PTR_W'(cnt_q - CW'(1));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[rd_ptr];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/node_tree_walker.sv
// Field-identifier tree walker over external synchronous node memory with ancestor stack.
// Optional NODE_TREE_WALKER_STATS_EN adds saturating lookup/miss counters.
module node_tree_walker
  import tree_pkg::*;
#(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned PAYLOAD_W = 16,
  parameter int unsigned MAX_DEPTH = 8,
  localparam int unsigned NODE_W   = ID_W + ADDR_W + CNT_W + PAYLOAD_W,
  localparam int unsigned DEPTH_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_rdy_o,
  input  logic              cmd_op_i,
  input  logic [ID_W-1:0]   field_id_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [NODE_W-1:0] mem_rd_data_i,
  output logic              node_valid_o,
  input  logic              node_rdy_i,
  output logic [NODE_W-1:0] node_o,
  output logic [ADDR_W-1:0] node_addr_o,
  output logic              node_miss_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic              err_o
`ifdef NODE_TREE_WALKER_STATS_EN
  ,
  output logic [15:0]       lookup_cnt_o,
  output logic [15:0]       miss_cnt_o
`endif
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH - 1);

  walker_state_e state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d, cnt_q, cnt_d;
  logic [ID_W-1:0]    fid_q, fid_d;
  logic [ADDR_W-1:0]  fc_q, fc_d, parent_q, parent_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [NODE_W-1:0]  resp_word_q, resp_word_d;
  logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d;
  logic               resp_miss_q, resp_miss_d;
  logic               resp_lookup_q, resp_lookup_d;
  logic               err_q, err_d, err_now;
  logic               push, pop, rd_en;
  logic [ADDR_W-1:0]  rd_addr, scan_addr, stk_top;
  logic               stk_full, stk_empty;

  logic [ID_W-1:0]    rd_id;
  logic [ADDR_W-1:0]  rd_fc, resp_fc;
  logic [CNT_W-1:0]   rd_cnt, resp_cnt;

  assign rd_id     = mem_rd_data_i[ID_W-1:0];
  assign rd_fc     = mem_rd_data_i[ID_W +: ADDR_W];
  assign rd_cnt    = mem_rd_data_i[ID_W+ADDR_W +: CNT_W];
  assign resp_fc   = resp_word_q[ID_W +: ADDR_W];
  assign resp_cnt  = resp_word_q[ID_W+ADDR_W +: CNT_W];
  assign scan_addr = fc_q + ADDR_W'(k_q);

  node_tree_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (parent_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    fid_d         = fid_q;
    fc_d          = fc_q;
    cnt_d         = cnt_q;
    parent_d      = parent_q;
    depth_d       = depth_q;
    resp_word_d   = resp_word_q;
    resp_addr_d   = resp_addr_q;
    resp_miss_d   = resp_miss_q;
    resp_lookup_d = resp_lookup_q;
    err_d         = 1'b0;
    err_now       = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    case (state_q)
      INIT: begin
        rd_en   = 1'b1;
        state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        fc_d    = rd_fc;
        cnt_d   = rd_cnt;
        state_d = IDLE;
      end
      IDLE: begin
        if (cmd_valid_i) begin
          if (walker_op_e'(cmd_op_i) == LOOKUP) begin
            fid_d   = field_id_i;
            k_d     = '0;
            state_d = SCAN;
          end else if (stk_empty) begin
            resp_word_d   = '0;
            resp_addr_d   = '0;
            resp_miss_d   = 1'b1;
            resp_lookup_d = 1'b0;
            err_d         = 1'b1;
            state_d       = RESP;
          end else begin
            pop      = 1'b1;
            parent_d = stk_top;
            depth_d  = depth_q - DEPTH_W'(1);
            state_d  = ASC_RD;
          end
        end
      end
      SCAN: begin
        if (k_q == cnt_q) begin
          resp_word_d   = '0;
          resp_addr_d   = '0;
          resp_miss_d   = 1'b1;
          resp_lookup_d = 1'b1;
          state_d       = RESP;
        end else begin
          rd_en   = 1'b1;
          rd_addr = scan_addr;
          state_d = CMP;
        end
      end
      CMP: begin
        if (rd_id == fid_q) begin
          resp_word_d   = mem_rd_data_i;
          resp_addr_d   = scan_addr;
          resp_miss_d   = 1'b0;
          resp_lookup_d = 1'b1;
          state_d       = RESP;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = SCAN;
        end
      end
      ASC_RD: begin
        rd_en   = 1'b1;
        rd_addr = parent_q;
        state_d = ASC_WAIT;
      end
      ASC_WAIT: begin
        fc_d          = rd_fc;
        cnt_d         = rd_cnt;
        resp_word_d   = mem_rd_data_i;
        resp_addr_d   = parent_q;
        resp_miss_d   = 1'b0;
        resp_lookup_d = 1'b0;
        state_d       = RESP;
      end
      RESP: begin
        if (node_rdy_i) begin
          state_d = IDLE;
          // Only a lookup hit on a node with children moves the parent pointer down.
          if (resp_lookup_q && !resp_miss_q && (resp_cnt != '0)) begin
            if (depth_q == DEPTH_MAX || stk_full) begin
              err_now = 1'b1;
            end else begin
              push     = 1'b1;
              parent_d = resp_addr_q;
              fc_d     = resp_fc;
              cnt_d    = resp_cnt;
              depth_d  = depth_q + DEPTH_W'(1);
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= INIT;
      k_q           <= '0;
      fid_q         <= '0;
      fc_q          <= '0;
      cnt_q         <= '0;
      parent_q      <= '0;
      depth_q       <= '0;
      resp_word_q   <= '0;
      resp_addr_q   <= '0;
      resp_miss_q   <= 1'b0;
      resp_lookup_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      fid_q         <= fid_d;
      fc_q          <= fc_d;
      cnt_q         <= cnt_d;
      parent_q      <= parent_d;
      depth_q       <= depth_d;
      resp_word_q   <= resp_word_d;
      resp_addr_q   <= resp_addr_d;
      resp_miss_q   <= resp_miss_d;
      resp_lookup_q <= resp_lookup_d;
      err_q         <= err_d;
    end
  end

  // INIT is also the state held during reset, so the read strobe is masked until release.
  assign mem_rd_en_o   = rd_en & reset_i;
  assign mem_rd_addr_o = rd_addr;
  assign cmd_rdy_o     = (state_q == IDLE);
  assign node_valid_o  = (state_q == RESP);
  assign node_o        = resp_word_q;
  assign node_addr_o   = resp_addr_q;
  assign node_miss_o   = resp_miss_q;
  assign depth_o       = depth_q;
  assign err_o         = err_q | err_now;

`ifdef NODE_TREE_WALKER_STATS_EN
  logic [15:0] lookup_cnt_q, miss_cnt_q;
  logic        lookup_acc, miss_hs;

  assign lookup_acc = (state_q == IDLE) && cmd_valid_i && (walker_op_e'(cmd_op_i) == LOOKUP);
  assign miss_hs    = (state_q == RESP) && node_rdy_i && resp_miss_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      lookup_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (lookup_acc && (lookup_cnt_q != '1)) lookup_cnt_q <= lookup_cnt_q + 16'd1;
      if (miss_hs && (miss_cnt_q != '1))      miss_cnt_q   <= miss_cnt_q + 16'd1;
    end
  end

  assign lookup_cnt_o = lookup_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
`endif

endmodule
